// File: rtl/lcd_scaled_image_timing.sv
// lcd_scaled_image_timing: panel sync/DE generator that overlays an
// integer-upscaled grayscale ROM image with a border on a background.
// The image bank and invert mode are latched once per frame.
module lcd_scaled_image_timing #(
   parameter int          H_ACTIVE     = 480,
   parameter int          H_FP         = 50,
   parameter int          H_SYNC       = 4,
   parameter int          H_BP         = 26,
   parameter int          V_ACTIVE     = 272,
   parameter int          V_FP         = 20,
   parameter int          V_SYNC       = 2,
   parameter int          V_BP         = 3,
   parameter int          IMG_W        = 28,
   parameter int          IMG_H        = 28,
   parameter int          SCALE        = 8,
   parameter int          X_OFF        = 128,
   parameter int          Y_OFF        = 24,
   parameter int          BORDER       = 2,
   parameter logic [15:0] BORDER_COLOR = 16'hF800,
   parameter logic [15:0] BG_COLOR     = 16'h0000,
   parameter int          PIX_W        = 8,
   parameter int          ROM_LAT      = 1,
   parameter int          ADDR_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bank_sel,
   input  logic              invert,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              lcd_hsync,
   output logic              lcd_vsync,
   output logic              lcd_de,
   output logic [4:0]        lcd_r,
   output logic [5:0]        lcd_g,
   output logic [4:0]        lcd_b,
   output logic              frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SY   = HW'(H_SYNC);
   localparam logic [HW-1:0] H_A0   = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_A1   = HW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [HW-1:0] H_W0   = HW'(H_SYNC + H_BP + X_OFF);
   localparam logic [HW-1:0] H_W1   = HW'(H_SYNC + H_BP + X_OFF + IMG_W * SCALE);
   localparam logic [HW-1:0] H_B0   = HW'(H_SYNC + H_BP + X_OFF - BORDER);
   localparam logic [HW-1:0] H_B1   = HW'(H_SYNC + H_BP + X_OFF + IMG_W * SCALE + BORDER);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
   localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [VW-1:0] V_W0   = VW'(V_SYNC + V_BP + Y_OFF);
   localparam logic [VW-1:0] V_W1   = VW'(V_SYNC + V_BP + Y_OFF + IMG_H * SCALE);
   localparam logic [VW-1:0] V_B0   = VW'(V_SYNC + V_BP + Y_OFF - BORDER);
   localparam logic [VW-1:0] V_B1   = VW'(V_SYNC + V_BP + Y_OFF + IMG_H * SCALE + BORDER);
   localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] IMG_N    = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   if ((X_OFF < BORDER) || (X_OFF + IMG_W * SCALE + BORDER > H_ACTIVE) ||
       (Y_OFF < BORDER) || (Y_OFF + IMG_H * SCALE + BORDER > V_ACTIVE)) begin : g_bad_window
      $error("image window plus border does not fit in the active area");
   end
   if ((2 ** ADDR_W) < 2 * IMG_W * IMG_H) begin : g_bad_addr_w
      $error("ADDR_W too small for two image banks");
   end
   if ((SCALE < 1) || (PIX_W < 6) || (ROM_LAT < 1) || (ROM_LAT > 2)) begin : g_bad_param
      $error("SCALE, PIX_W or ROM_LAT out of range");
   end

   // region: 0 background, 1 border, 2 image
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic       inv;
      logic [1:0] rgn;
   } pipe_t;

   localparam pipe_t FLUSH = '{hs: 1'b1, vs: 1'b1, default: '0};

   logic [HW-1:0]     h, h_nxt;
   logic [VW-1:0]     v, v_nxt;
   logic              line_end, frame_end;
   logic              bank, inv;
   logic [SW-1:0]     xs, ys;
   logic [ADDR_W-1:0] xcol, row_base;
   logic              h_win, v_win, h_brd, v_brd;
   pipe_t             cur, last;
   pipe_t             pipe [ROM_LAT];
   logic [PIX_W-1:0]  g;
   logic [15:0]       rgb_nxt;

   // next counter position and wrap detection
   always_comb begin
      line_end  = (h == H_LAST);
      frame_end = line_end && (v == V_LAST);
      h_nxt     = line_end ? '0 : h + HW'(1);
      v_nxt     = v;
      if (line_end) v_nxt = frame_end ? '0 : v + VW'(1);
   end

   // raster counters; bank/invert latched on the edge entering (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         h    <= '0;
         v    <= '0;
         bank <= 1'b0;
         inv  <= 1'b0;
      end else begin
         h <= h_nxt;
         v <= v_nxt;
         if (frame_end) begin
            bank <= bank_sel;
            inv  <= invert;
         end
      end
   end

   // sub-pixel counters: column index steps every SCALE clocks, row base every SCALE lines
   always_ff @(posedge clk) begin
      if (rst) begin
         xs       <= '0;
         xcol     <= '0;
         ys       <= '0;
         row_base <= '0;
      end else begin
         if (h_nxt == H_W0) begin
            xs   <= '0;
            xcol <= '0;
         end else if (xs == S_LAST) begin
            xs   <= '0;
            xcol <= xcol + ADDR_W'(1);
         end else begin
            xs <= xs + SW'(1);
         end
         if (line_end) begin
            if (v_nxt == V_W0) begin
               ys       <= '0;
               row_base <= '0;
            end else if (ys == S_LAST) begin
               ys       <= '0;
               row_base <= row_base + ROW_STEP;
            end else begin
               ys <= ys + SW'(1);
            end
         end
      end
   end

   // region decode and ROM address for the current counter position
   always_comb begin
      h_win    = (h >= H_W0) && (h < H_W1);
      v_win    = (v >= V_W0) && (v < V_W1);
      h_brd    = (h >= H_B0) && (h < H_B1);
      v_brd    = (v >= V_B0) && (v < V_B1);
      rom_addr = (bank ? IMG_N : '0) + ((h_win && v_win) ? (row_base + xcol) : '0);
      cur      = FLUSH;
      cur.hs   = (h >= H_SY);
      cur.vs   = (v >= V_SY);
      cur.de   = (h >= H_A0) && (h < H_A1) && (v >= V_A0) && (v < V_A1);
      cur.fs   = (h == '0) && (v == '0);
      cur.inv  = inv;
      cur.rgn  = (h_win && v_win) ? 2'd2 : ((h_brd && v_brd) ? 2'd1 : 2'd0);
   end

   // delay line that waits out the ROM latency
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) pipe[i] <= FLUSH;
      end else begin
         pipe[0] <= cur;
         for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // pixel colour selection once ROM data is aligned with its position
   always_comb begin
      last    = pipe[ROM_LAT-1];
      g       = last.inv ? ~rom_data : rom_data;
      rgb_nxt = 16'h0000;
      if (last.de) begin
         case (last.rgn)
            2'd2:    rgb_nxt = {g[PIX_W-1 -: 5], g[PIX_W-1 -: 6], g[PIX_W-1 -: 5]};
            2'd1:    rgb_nxt = BORDER_COLOR;
            default: rgb_nxt = BG_COLOR;
         endcase
      end
   end

   // registered panel outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_hsync   <= 1'b1;
         lcd_vsync   <= 1'b1;
         lcd_de      <= 1'b0;
         frame_start <= 1'b0;
         lcd_r       <= '0;
         lcd_g       <= '0;
         lcd_b       <= '0;
      end else begin
         lcd_hsync   <= last.hs;
         lcd_vsync   <= last.vs;
         lcd_de      <= last.de;
         frame_start <= last.fs;
         lcd_r       <= rgb_nxt[15:11];
         lcd_g       <= rgb_nxt[10:5];
         lcd_b       <= rgb_nxt[4:0];
      end
   end

endmodule

// File: tb/tb_lcd_scaled_image_timing.sv
// Bench for lcd_scaled_image_timing on a reduced panel (49x29 clocks per frame).
// Two instances (ROM latency 1 and 2) share stimulus; a reference model pushes
// expected outputs into per-instance queues that monitors pop and compare.
module tb_lcd_scaled_image_timing;
   localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 2, H_BP = 3;
   localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 1, V_BP = 2;
   localparam int IMG_W = 4, IMG_H = 3, SCALE = 3, X_OFF = 10, Y_OFF = 5, BORDER = 2;
   localparam int ADDR_W = 5;
   localparam int H_TOTAL = 49, V_TOTAL = 29, HA0 = 5, VA0 = 3, IMG_N = 12;
   localparam int FRAME = H_TOTAL * V_TOTAL;
   localparam logic [19:0] FLUSH = 20'hC0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bank_sel = 1'b0;
   logic invert = 1'b0;
   logic rom_ff = 1'b0;

   logic [4:0] ra1, ra2;
   logic [7:0] rd1, rd2a, rd2;
   logic hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
   logic [4:0] r1, b1, r2, b2;
   logic [5:0] g1, g2;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mh = 0, mv = 0;
   bit mbank = 0, minv = 0;

   typedef struct {
      int          due;
      logic [19:0] val;
   } exp_t;
   exp_t q1[$], q2[$], qa[$];

   always #5 clk = ~clk;

   lcd_scaled_image_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
      .BORDER(BORDER), .BORDER_COLOR(16'hF800), .BG_COLOR(16'h0000),
      .PIX_W(8), .ROM_LAT(1), .ADDR_W(ADDR_W)
   ) u1 (
      .clk(clk), .rst(rst), .bank_sel(bank_sel), .invert(invert),
      .rom_addr(ra1), .rom_data(rd1),
      .lcd_hsync(hs1), .lcd_vsync(vs1), .lcd_de(de1),
      .lcd_r(r1), .lcd_g(g1), .lcd_b(b1), .frame_start(fs1)
   );

   lcd_scaled_image_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
      .BORDER(BORDER), .BORDER_COLOR(16'hF800), .BG_COLOR(16'h0000),
      .PIX_W(8), .ROM_LAT(2), .ADDR_W(ADDR_W)
   ) u2 (
      .clk(clk), .rst(rst), .bank_sel(bank_sel), .invert(invert),
      .rom_addr(ra2), .rom_data(rd2),
      .lcd_hsync(hs2), .lcd_vsync(vs2), .lcd_de(de2),
      .lcd_r(r2), .lcd_g(g2), .lcd_b(b2), .frame_start(fs2)
   );

   function automatic logic [7:0] rom_val(input logic [4:0] a);
      return rom_ff ? 8'hFF : {a[3:0], a[3:0]};
   endfunction

   always @(posedge clk) begin
      rd1  <= rom_val(ra1);
      rd2a <= rom_val(ra2);
      rd2  <= rd2a;
   end

   function automatic bit in_win(input int h, input int v);
      int x = h - HA0;
      int y = v - VA0;
      return (x >= X_OFF) && (x < X_OFF + IMG_W * SCALE) && (y >= Y_OFF) && (y < Y_OFF + IMG_H * SCALE);
   endfunction

   function automatic int m_addr(input int h, input int v, input bit b);
      int a = b ? IMG_N : 0;
      if (in_win(h, v)) a += ((v - VA0 - Y_OFF) / SCALE) * IMG_W + (h - HA0 - X_OFF) / SCALE;
      return a;
   endfunction

   function automatic logic [19:0] m_out(input int h, input int v, input bit b, input bit inv);
      int x = h - HA0;
      int y = v - VA0;
      logic hs, vs, de, fs;
      logic [15:0] rgb;
      logic [7:0] gr;
      bit brd;
      hs  = (h >= H_SYNC);
      vs  = (v >= V_SYNC);
      de  = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
      fs  = (h == 0) && (v == 0);
      brd = (x >= X_OFF - BORDER) && (x < X_OFF + IMG_W * SCALE + BORDER) &&
            (y >= Y_OFF - BORDER) && (y < Y_OFF + IMG_H * SCALE + BORDER);
      rgb = 16'h0000;
      if (de) begin
         if (in_win(h, v)) begin
            gr  = rom_val(5'(m_addr(h, v, b))) ^ {8{inv}};
            rgb = {gr[7:3], gr[7:2], gr[7:3]};
         end else if (brd) begin
            rgb = 16'hF800;
         end
      end
      return {hs, vs, de, fs, rgb};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   int  st_len, st_de, st_hsl, st_hsp, st_vsl;
   bit  st_valid = 0;
   logic st_hprev = 1'b1;

   // reference model: tracks the raster and queues expected responses
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mh = 0; mv = 0; mbank = 0; minv = 0;
         st_valid = 0;
         q1.delete();
         q2.delete();
         for (int k = 0; k < 2; k++) q1.push_back('{cyc + k, FLUSH});
         for (int k = 0; k < 3; k++) q2.push_back('{cyc + k, FLUSH});
      end else if (mh == H_TOTAL - 1) begin
         mh = 0;
         if (mv == V_TOTAL - 1) begin
            mv = 0; mbank = bank_sel; minv = invert;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      q1.push_back('{cyc + 2, m_out(mh, mv, mbank, minv)});
      q2.push_back('{cyc + 3, m_out(mh, mv, mbank, minv)});
      qa.push_back('{cyc, 20'(m_addr(mh, mv, mbank))});
   end

   // output monitors
   always @(negedge clk) begin
      exp_t e;
      while (qa.size() > 0 && qa[0].due <= cyc) begin
         e = qa.pop_front();
         chk("rom_addr_lat1", 32'(ra1), 32'(e.val));
         chk("rom_addr_lat2", 32'(ra2), 32'(e.val));
      end
      while (q1.size() > 0 && q1[0].due <= cyc) begin
         e = q1.pop_front();
         chk("out_lat1", 32'({hs1, vs1, de1, fs1, r1, g1, b1}), 32'(e.val));
      end
      while (q2.size() > 0 && q2[0].due <= cyc) begin
         e = q2.pop_front();
         chk("out_lat2", 32'({hs2, vs2, de2, fs2, r2, g2, b2}), 32'(e.val));
      end
   end

   // per-frame statistics between consecutive frame_start pulses
   always @(negedge clk) begin
      if (fs1) begin
         if (st_valid) begin
            chk("frame_len", 32'(st_len), 32'(FRAME));
            chk("de_count", 32'(st_de), 32'(H_ACTIVE * V_ACTIVE));
            chk("hsync_low_clocks", 32'(st_hsl), 32'(V_TOTAL * H_SYNC));
            chk("hsync_pulses", 32'(st_hsp), 32'(V_TOTAL));
            chk("vsync_low_clocks", 32'(st_vsl), 32'(V_SYNC * H_TOTAL));
         end
         st_valid = 1;
         st_len = 0; st_de = 0; st_hsl = 0; st_hsp = 0; st_vsl = 0;
      end
      st_len++;
      if (de1) st_de++;
      if (!hs1) st_hsl++;
      if (!hs1 && st_hprev) st_hsp++;
      if (!vs1) st_vsl++;
      st_hprev = hs1;
   end

   task automatic wait_pos(input int h, input int v);
      int n = 0;
      while (!(mh == h && mv == v)) begin
         @(negedge clk);
         n++;
         if (n > 4000) begin
            total++;
            bad++;
            $display("FAIL wait_pos(%0d,%0d) timeout: at (%0d,%0d)", h, v, mh, mv);
            return;
         end
      end
   endtask

   task automatic chk_addr(input int h, input int v, input int exp);
      wait_pos(h, v);
      chk($sformatf("addr(%0d,%0d)_lat1", h, v), 32'(ra1), 32'(exp));
      chk($sformatf("addr(%0d,%0d)_lat2", h, v), 32'(ra2), 32'(exp));
   endtask

   task automatic chk_pix(input int h, input int v, input logic [16:0] exp);
      wait_pos(h, v);
      repeat (2) @(negedge clk);
      chk($sformatf("pix(%0d,%0d)_lat1", h, v), 32'({de1, r1, g1, b1}), 32'(exp));
      @(negedge clk);
      chk($sformatf("pix(%0d,%0d)_lat2", h, v), 32'({de2, r2, g2, b2}), 32'(exp));
   endtask

   task automatic chk_fs_after_release();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("fs_lat1_k%0d", k), 32'(fs1), 32'(k == 2));
         chk($sformatf("fs_lat2_k%0d", k), 32'(fs2), 32'(k == 3));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_out_lat1", 32'({hs1, vs1, de1, fs1, r1, g1, b1}), 32'(FLUSH));
      chk("reset_addr", 32'(ra1), 32'd0);
      rst = 1'b0;
      chk_fs_after_release();

      // frame 0, bank 0
      chk_addr(15, 8, 0);
      chk_addr(17, 8, 0);
      chk_addr(18, 8, 1);
      chk_addr(26, 8, 3);
      chk_addr(15, 11, 4);
      chk_pix(18, 11, {1'b1, 16'h52AA});
      wait_pos(0, 13);
      bank_sel = 1'b1;
      chk_addr(26, 16, 11);
      chk_addr(27, 16, 0);

      // frame 1, bank 1
      chk_addr(0, 0, 12);
      chk_addr(15, 8, 12);
      chk_addr(26, 16, 23);
      chk_addr(27, 16, 12);
      wait_pos(0, 27);
      bank_sel = 1'b0;
      invert   = 1'b1;
      rom_ff   = 1'b1;

      // frame 2, bank 0, inverted all-ones image
      chk_addr(15, 8, 0);
      chk_pix(2, 10, {1'b0, 16'h0000});
      chk_pix(12, 12, {1'b1, 16'h0000});
      chk_pix(13, 13, {1'b1, 16'hF800});
      chk_pix(18, 14, {1'b1, 16'h0000});

      // mid-frame reset
      wait_pos(30, 15);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_out_lat1", 32'({hs1, vs1, de1, fs1, r1, g1, b1}), 32'(FLUSH));
      chk("midreset_out_lat2", 32'({hs2, vs2, de2, fs2, r2, g2, b2}), 32'(FLUSH));
      chk("midreset_addr", 32'(ra2), 32'd0);
      chk("midreset_pos", 32'({mh[15:0], mv[15:0]}), 32'd0);
      rst = 1'b0;
      chk_fs_after_release();

      repeat (2 * FRAME + 50) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lcd_scaled_image_timing.md
# lcd_scaled_image_timing

Parametrised LCD timing generator with integer-scaled image display for the RGB565 LCD output path. It produces HSYNC/VSYNC/DE for a configurable panel. It fetches a grayscale IMG_W x IMG_H image from an external synchronous ROM with ROM_LAT latency, upscales it by SCALE, and places it at (X_OFF, Y_OFF) with a coloured border. It selects one of two ROM image banks per frame and supports a per-frame invert mode.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP / H_SYNC / H_BP, 50 / 4 / 26, horizontal front porch / sync width / back porch (clocks)
- V_ACTIVE, 272, visible lines
- V_FP / V_SYNC / V_BP, 20 / 2 / 3, vertical front porch / sync width / back porch (lines)
- IMG_W / IMG_H, 28 / 28, source image size
- SCALE, 8, integer upscale factor (>=1)
- X_OFF / Y_OFF, 128 / 24, image top-left in active coordinates
- BORDER, 2, border width in pixels around the scaled image (0 = none)
- BORDER_COLOR / BG_COLOR, 16'hF800 / 16'h0000, RGB565 colours
- PIX_W, 8, ROM data width (>=6)
- ROM_LAT, 1, ROM read latency in clocks (1 or 2)
- ADDR_W, 11, ROM address width; must hold 2*IMG_W*IMG_H-1
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- bank_sel  in  1  image bank for the next frame
- invert  in  1  invert grayscale for the next frame
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  PIX_W  ROM data, valid ROM_LAT clocks after rom_addr
- lcd_hsync / lcd_vsync  out  1  active-low syncs
- lcd_de  out  1  data enable
- lcd_r / lcd_g / lcd_b  out  5 / 6 / 5  RGB565 pixel
- frame_start  out  1  one-clock pulse at the first output clock of each frame

## Operation
- Line length: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. Frame height: V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters: h 0..H_TOTAL-1. h wraps and advances v 0..V_TOTAL-1; v wraps to 0 after V_TOTAL-1.
- Within each count, the phase order is sync, back porch, active, front porch.
- hsync is low for h < H_SYNC. vsync is low for v < V_SYNC.
- DE is high when h is in [H_SYNC+H_BP, +H_ACTIVE) and v is in [V_SYNC+V_BP, +V_ACTIVE).
- Active coordinates: x = h-(H_SYNC+H_BP), y = v-(V_SYNC+V_BP).
- Image window: X_OFF <= x < X_OFF+IMG_W*SCALE, and the same form for y.
  - rom_addr = bank*IMG_W*IMG_H + ((y-Y_OFF)/SCALE)*IMG_W + (x-X_OFF)/SCALE.
  - The address is generated incrementally with sub-pixel counters. There is no divider on the pixel path.
  - Outside the window, rom_addr = bank*IMG_W*IMG_H.
- Border: pixels outside the window but within BORDER pixels of it (rectangular) output BORDER_COLOR.
- Other active pixels output BG_COLOR.
- Inactive pixels output RGB = 0.
- Image pixel path:
  - g = invert ? ~rom_data : rom_data.
  - R = g[PIX_W-1 -: 5], G = g[PIX_W-1 -: 6], B = g[PIX_W-1 -: 5].
- bank_sel and invert are sampled on the edge where the counters become (0,0). They are held for the whole frame. Mid-frame changes have no effect until the next frame.
- Parameter violations must be flagged at elaboration time. These are: the window plus border exceeding the active area, and ADDR_W being too small.

## Timing
- Output latency: all outputs (syncs, DE, RGB, frame_start) for counter position (h,v) appear exactly ROM_LAT+1 clocks after the counters hold (h,v).
- rom_addr for (h,v) is presented while the counters hold (h,v). The sync/DE/region pipeline is ROM_LAT+1 deep so that rom_data aligns with it.
- Frame period: H_TOTAL*V_TOTAL clocks. With defaults this is 560*297 = 166320.
- Reset, while rst is high at an edge:
  - counters = (0,0), bank = 0, invert = 0, rom_addr = 0.
  - The pipeline is flushed: lcd_hsync = 1, lcd_vsync = 1, lcd_de = 0, RGB = 0, frame_start = 0.
- Counters are at (0,0) on the first clock after reset deasserts. frame_start pulses ROM_LAT+1 clocks later.
- Reset mid-frame: it takes effect at the next edge. No partial-line outputs leak after reset, because the pipeline is flushed.
- Simultaneous h wrap and v wrap: the counters become (0,0) and the bank/invert sample happens on that same edge.

## Test plan
- Defaults, reset for 3 clocks, then run 2 frames. Required response:
  - 297 hsync-low pulses of 4 clocks per frame.
  - vsync low for 2*560 clocks.
  - 130560 DE-high clocks per frame.
  - frame_start pulses spaced 166320 clocks apart, the first at clock ROM_LAT+1 after reset release.
- Address walk, bank 0. rom_addr must read:
  - 0 for x = 128..135, y = 24.
  - 1 at x = 136.
  - 27 at x = 351.
  - 28 at (128, 32).
  - 783 at (351, 247).
  - 0 at (352, 247).
- ROM model with ROM_LAT = 2 and data = addr[7:0]. Image pixel with address 0x55 must give R = 5'h0A, G = 6'h15, B = 5'h0A, aligned with its DE clock. Repeat with ROM_LAT = 1.
- bank_sel toggled to 1 at y = 100. Required response:
  - The current frame keeps addresses 0..783.
  - The next frame's window addresses run 784..1567.
  - Outside the window rom_addr = 784.
- invert = 1 and ROM data 0xFF, applied next frame. Required response:
  - Image pixels are RGB 0.
  - (126, 100) gives 16'hF800 (border).
  - (125, 100) gives 16'h0000 (background).
  - Inactive pixels are 0.
- rst pulsed for 1 clock at h = 300, v = 150. Required response:
  - The next clock shows reset output values.
  - The counters restart at (0,0).
  - frame_start comes ROM_LAT+1 clocks after reset release.
